bcd_serial_add_ctrl: RTL

//  Sequencer for wide packed-BCD addition over a single shared 2-digit BCD adder slice.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_pair_add.sv | 25 ++
 rtl/bcd_serial_add_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and the single-digit decimal add rule used by the BCD adder slice.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // Returns {c_out, digit}; invalid nibbles follow the same rule, flagged elsewhere.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       c);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0, c};
    if (s > {1'b0, BCD_MAX}) return {1'b1, s[3:0] + BCD_CORR};
    else                     return {1'b0, s[3:0]};
  endfunction

endpackage

// File: rtl/bcd_digit_pair_add.sv
// Combinational two-digit BCD adder slice with per-digit invalid-nibble flags.
module bcd_digit_pair_add
  import bcd_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic [1:0] bad
);

  logic [4:0] lo;
  logic [4:0] hi;

  always_comb begin
    lo   = bcd_digit_add(a[3:0], b[3:0], cin);
    hi   = bcd_digit_add(a[7:4], b[7:4], lo[4]);
    sum  = {hi[3:0], lo[3:0]};
    cout = hi[4];
    bad[0] = (a[3:0] > BCD_MAX) || (b[3:0] > BCD_MAX);
    bad[1] = (a[7:4] > BCD_MAX) || (b[7:4] > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder: one digit pair per cycle through a shared slice,
// with valid/ready handshakes on operands and result.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG = 8,
  parameter int unsigned PW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err
);

  localparam logic [PW-1:0] LAST = PW'(NDIG / 2 - 1);

  state_t            state;
  state_t            state_nx;
  logic [PW-1:0]     idx;
  logic              carry;
  logic [4*NDIG-1:0] a_q;
  logic [4*NDIG-1:0] b_q;

  logic [7:0]        pair_a;
  logic [7:0]        pair_b;
  logic [7:0]        pair_sum;
  logic              pair_cout;
  logic [1:0]        pair_bad;

  assign pair_a = a_q[8*idx +: 8];
  assign pair_b = b_q[8*idx +: 8];

  bcd_digit_pair_add u_slice (
    .a    (pair_a),
    .b    (pair_b),
    .cin  (carry),
    .sum  (pair_sum),
    .cout (pair_cout),
    .bad  (pair_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ADD;
      end
      ADD: begin
        if (idx == LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
          end
        end
        ADD: begin
          sum[8*idx +: 8] <= pair_sum;
          carry           <= pair_cout;
          err             <= err | (|pair_bad);
          if (idx == LAST) cout <= pair_cout;
          else             idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
